// File: rtl/grf_wb_tracer.sv
// grf_wb_tracer: captures GRF writeback events into a FIFO stream, keeps a 32-entry shadow register file, and counts dropped events.
// Optional build macro GRF_TRACE_DEDUP_EN suppresses events whose data matches the current shadow value.
module grf_wb_tracer #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       w_grf_we,
  input  logic [4:0]                 w_grf_addr,
  input  logic [31:0]                w_grf_wdata,
  input  logic [31:0]                w_inst_addr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [4:0]                 out_addr,
  output logic [31:0]                out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_cnt,
  input  logic [4:0]                 rd_addr,
  output logic [31:0]                rd_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [68:0]   mem [DEPTH];
  logic [31:0]   shadow [32];
  logic [AW-1:0] wptr, rptr;
  logic          qual, dup, ev, pop, push, drop;
  assign qual = w_grf_we && (w_grf_addr != 5'd0);
`ifdef GRF_TRACE_DEDUP_EN
  assign dup = w_grf_wdata == shadow[w_grf_addr];
`else
  assign dup = 1'b0;
`endif
  assign ev        = qual && !dup;
  assign out_valid = count != '0;
  assign full      = count == CW'(DEPTH);
  assign pop       = out_valid && out_ready;
  // a pop on the same edge frees the slot, so a full FIFO can still accept
  assign push      = ev && (!full || pop);
  assign drop      = ev && full && !pop;
  assign out_pc    = out_valid ? mem[rptr][68:37] : '0;
  assign out_addr  = out_valid ? mem[rptr][36:32] : '0;
  assign out_data  = out_valid ? mem[rptr][31:0]  : '0;
  assign rd_data   = rd_addr == 5'd0 ? '0 :
                     (qual && rd_addr == w_grf_addr) ? w_grf_wdata : shadow[rd_addr];
  always_ff @(posedge clk) if (push) mem[wptr] <= {w_inst_addr, w_grf_addr, w_grf_wdata};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      for (int i = 0; i < 32; i++) shadow[i] <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (drop) overflow <= 1'b1;
      if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
      if (qual) shadow[w_grf_addr] <= w_grf_wdata;
    end
  end
endmodule

// File: tb/tb_grf_wb_tracer.sv
// tb_grf_wb_tracer: scoreboard bench with a queue-based reference model of the writeback tracer.
module tb_grf_wb_tracer;
  localparam int DEPTH = 8;
  logic        clk = 0, reset = 1;
  logic        w_grf_we = 0, out_ready = 0;
  logic [4:0]  w_grf_addr = 0, rd_addr = 0, out_addr;
  logic [31:0] w_grf_wdata = 0, w_inst_addr = 0, out_pc, out_data, rd_data;
  logic [3:0]  count;
  logic        out_valid, full, overflow;
  logic [15:0] drop_cnt;
  grf_wb_tracer #(.DEPTH(DEPTH), .DROP_W(16)) dut (
    .clk(clk), .reset(reset), .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr),
    .w_grf_wdata(w_grf_wdata), .w_inst_addr(w_inst_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data),
    .count(count), .full(full), .overflow(overflow), .drop_cnt(drop_cnt),
    .rd_addr(rd_addr), .rd_data(rd_data));
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic [68:0] sb [$];
  logic [31:0] mshadow [32];
  int          mcount = 0;
  logic        mov = 0;
  logic [15:0] mdrop = 0;
  task automatic chk(string name, logic [68:0] act, logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    sb.delete();
    mcount = 0;
    mov = 0;
    mdrop = 0;
    for (int i = 0; i < 32; i++) mshadow[i] = 0;
  endtask
  task automatic check_state();
    chk("count", 69'(count), 69'(mcount));
    chk("full", 69'(full), 69'(mcount == DEPTH));
    chk("out_valid", 69'(out_valid), 69'(mcount != 0));
    chk("overflow", 69'(overflow), 69'(mov));
    chk("drop_cnt", 69'(drop_cnt), 69'(mdrop));
    if (mcount != 0) chk("head", {out_pc, out_addr, out_data}, sb[0]);
  endtask
  // one clock: check state, drive inputs, advance model for the coming edge, check rd_data
  task automatic cyc(logic we, logic [4:0] a, logic [31:0] d, logic [31:0] pc, logic rdy, logic [4:0] ra);
    logic qual, dup, pop;
    logic [31:0] rexp;
    @(negedge clk);
    #1;
    check_state();
    w_grf_we = we; w_grf_addr = a; w_grf_wdata = d; w_inst_addr = pc;
    out_ready = rdy; rd_addr = ra;
    qual = we && a != 0;
`ifdef GRF_TRACE_DEDUP_EN
    dup = qual && mshadow[a] == d;
`else
    dup = 0;
`endif
    rexp = ra == 0 ? 32'd0 : (qual && ra == a) ? d : mshadow[ra];
    pop = mcount > 0 && rdy;
    if (pop) mcount--;
    if (qual && !dup) begin
      if (mcount < DEPTH) begin
        sb.push_back({pc, a, d});
        mcount++;
      end else begin
        mov = 1;
        if (mdrop != 16'hFFFF) mdrop++;
      end
    end
    if (qual) mshadow[a] = d;
    #2;
    chk("rd_data", 69'(rd_data), 69'(rexp));
  endtask
  always begin
    @(negedge clk);
    #2;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 69'(1), 69'(0));
      else chk("drain_event", {out_pc, out_addr, out_data}, sb.pop_front());
    end
  end
  initial begin
    model_reset();
    #1;
    chk("rst_valid", 69'(out_valid), 69'(0));
    chk("rst_count", 69'(count), 69'(0));
    @(negedge clk);
    reset = 0;
    cyc(1, 5, 32'h12345678, 32'h3000, 0, 5);
    cyc(0, 0, 0, 0, 0, 5);
    chk("basic_addr", 69'(out_addr), 69'(5));
    chk("basic_data", 69'(out_data), 69'h12345678);
    chk("basic_pc", 69'(out_pc), 69'h3000);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 0, 32'hFFFFFFFF, 32'h3004, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("zero_count", 69'(count), 69'(0));
    chk("zero_drop", 69'(drop_cnt), 69'(0));
    for (int i = 1; i <= 10; i++) cyc(1, 5'(i), $urandom, 32'h4000 + 4 * i, 0, 5'(i));
    cyc(0, 0, 0, 0, 0, 9);
    chk("ovf_count", 69'(count), 69'(8));
    chk("ovf_full", 69'(full), 69'(1));
    chk("ovf_flag", 69'(overflow), 69'(1));
    chk("ovf_drop", 69'(drop_cnt), 69'(2));
    cyc(1, 3, 32'hC0FFEE03, 32'h5000, 1, 3);
    cyc(0, 0, 0, 0, 0, 10);
    chk("fullpop_count", 69'(count), 69'(8));
    chk("fullpop_drop", 69'(drop_cnt), 69'(2));
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1, 5'(9 + i % 2));
    cyc(1, 4, 32'hA, 32'h6000, 0, 4);
    cyc(1, 4, 32'hA, 32'h6004, 0, 4);
    cyc(0, 0, 0, 0, 0, 4);
`ifdef GRF_TRACE_DEDUP_EN
    chk("dedup_count", 69'(count), 69'(1));
`else
    chk("dedup_count", 69'(count), 69'(2));
`endif
    cyc(1, 7, 32'h77, 32'h6008, 0, 7);
    @(negedge clk);
    #3;
    reset = 1;
    w_grf_we = 0; out_ready = 0;
    #1;
    model_reset();
    check_state();
    for (int i = 1; i < 32; i++) begin
      rd_addr = 5'(i);
      #0.1;
      chk("rst_shadow", 69'(rd_data), 69'(0));
    end
    @(negedge clk);
    reset = 0;
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 600; i++)
        cyc($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
            $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom, $urandom,
            $urandom_range(0, 3) < p, 5'($urandom_range(0, 31)));
    for (int i = 0; i < 100 && mcount != 0; i++) cyc(0, 0, 0, 0, 1, 5'($urandom_range(0, 31)));
    cyc(0, 0, 0, 0, 0, 0);
    chk("final_empty", 69'(sb.size()), 69'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
